// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state enums, frame width and bit-clock divider helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_W     = $clog2(DATA_BITS + 1);

  typedef enum logic {TxIdle, TxTransfer} tx_state_t;
  typedef enum logic {RxIdle, RxStart}    rx_state_t;

  function automatic int unsigned clk_div(input int unsigned clk_freq,
                                          input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Signal bundle for the UART; uclktx/uclkrx are monitor-only copies of the internal bit clocks.
interface uart_if;
  logic       clk;
  logic       rst;
  logic       rx;
  logic       newd;
  logic [7:0] dintx;
  logic       tx;
  logic       donetx;
  logic       donerx;
  logic [7:0] doutrx;
  logic       uclktx;
  logic       uclkrx;
endinterface

// File: rtl/uart_rx.sv
// UART receiver: samples rx on each bit-clock rising edge after a low start sample.
// Define UART_ASSERT_EN to compile the built-in SVA checks.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 donerx,
  output logic [DATA_BITS-1:0] doutrx
);

  localparam int unsigned DIV   = clk_div(clk_freq, baud_rate);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic                 uclk;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_half;
  logic                 w_tick;
  logic [1:0]           r_rx_sync;
  logic                 w_rx;
  rx_state_t            r_state;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_done;

  assign w_half = (r_cnt == CNT_W'(HALF - 1));
  assign w_tick = w_half && !uclk;
  assign w_rx   = r_rx_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      uclk  <= 1'b0;
    end else if (w_half) begin
      r_cnt <= '0;
      uclk  <= ~uclk;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // rx comes from off-chip; resync resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_sync <= 2'b11;
    else     r_rx_sync <= {r_rx_sync[0], rx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RxIdle;
      r_bit   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
    end else if (w_tick) begin
      unique case (r_state)
        RxIdle: begin
          r_done <= 1'b0;
          r_bit  <= '0;
          if (!w_rx) r_state <= RxStart;
        end
        RxStart: begin
          r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
          if (r_bit == BIT_W'(DATA_BITS - 1)) begin
            r_dout  <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_done  <= 1'b1;
            r_bit   <= '0;
            r_state <= RxIdle;
          end else begin
            r_bit <= r_bit + BIT_W'(1);
          end
        end
        default: r_state <= RxIdle;
      endcase
    end
  end

  assign donerx = r_done;
  assign doutrx = r_dout;

`ifdef UART_ASSERT_EN
  if (DIV < 2) begin : g_div_chk
    $error("uart_rx: clk_freq/baud_rate must be at least 2");
  end

  a_done_hold: assert property (@(posedge clk) disable iff (rst)
    !w_tick |=> $stable(r_done));
  a_done_one: assert property (@(posedge clk) disable iff (rst)
    (w_tick && r_done) |=> !r_done);
`endif

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing driven from a divided bit clock uclk.
// Define UART_ASSERT_EN to compile the built-in SVA checks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 newd,
  input  logic [DATA_BITS-1:0] dintx,
  output logic                 tx,
  output logic                 donetx
);

  localparam int unsigned DIV   = clk_div(clk_freq, baud_rate);
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic                 uclk;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_half;
  logic                 w_tick;
  tx_state_t            r_state;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_tx;
  logic                 r_done;

  assign w_half = (r_cnt == CNT_W'(HALF - 1));
  // Framing updates on the clk edge where uclk rises, so everything stays in one clock domain.
  assign w_tick = w_half && !uclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      uclk  <= 1'b0;
    end else if (w_half) begin
      r_cnt <= '0;
      uclk  <= ~uclk;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= TxIdle;
      r_bit   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else if (w_tick) begin
      unique case (r_state)
        TxIdle: begin
          r_done <= 1'b0;
          if (newd) begin
            r_data  <= dintx;
            r_tx    <= 1'b0;
            r_state <= TxTransfer;
          end else begin
            r_tx <= 1'b1;
          end
        end
        TxTransfer: begin
          if (r_bit == BIT_W'(DATA_BITS)) begin
            r_tx    <= 1'b1;
            r_done  <= 1'b1;
            r_bit   <= '0;
            r_state <= TxIdle;
          end else begin
            r_tx   <= r_data[0];
            r_data <= r_data >> 1;
            r_bit  <= r_bit + BIT_W'(1);
          end
        end
        default: r_state <= TxIdle;
      endcase
    end
  end

  assign tx     = r_tx;
  assign donetx = r_done;

`ifdef UART_ASSERT_EN
  if (DIV < 2) begin : g_div_chk
    $error("uart_tx: clk_freq/baud_rate must be at least 2");
  end

  a_idle_tx_high: assert property (@(posedge clk) disable iff (rst)
    (r_state == TxIdle) |-> r_tx);
  a_done_hold: assert property (@(posedge clk) disable iff (rst)
    !w_tick |=> $stable(r_done));
  a_done_one: assert property (@(posedge clk) disable iff (rst)
    (w_tick && r_done) |=> !r_done);
`endif

endmodule

// File: rtl/uart_top.sv
// UART top: independent TX and RX halves whose bit clocks start in phase at reset release.
// UART_ASSERT_EN enables SVA checks inside the sub-modules.
module uart_top
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 newd,
  input  logic [DATA_BITS-1:0] dintx,
  output logic                 tx,
  output logic                 donetx,
  output logic                 donerx,
  output logic [DATA_BITS-1:0] doutrx
);

  uart_tx #(
    .clk_freq (clk_freq),
    .baud_rate(baud_rate)
  ) utx (
    .clk   (clk),
    .rst   (rst),
    .newd  (newd),
    .dintx (dintx),
    .tx    (tx),
    .donetx(donetx)
  );

  uart_rx #(
    .clk_freq (clk_freq),
    .baud_rate(baud_rate)
  ) rtx (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .donerx(donerx),
    .doutrx(doutrx)
  );

endmodule

// File: tb/tb_uart_top.sv
// Randomized scoreboard bench for uart_top: a line-level UART decoder checks tx frames,
// a receive monitor checks doutrx against bytes queued by the stimulus.
module tb_uart_top;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned DIV      = CLK_FREQ / BAUD;

  uart_if u_if ();

  logic        r_loop   = 1'b0;
  logic        r_rx_drv = 1'b1;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_donetx = 0;
  int          got_donetx = 0;
  int          exp_donerx = 0;
  int          got_donerx = 0;
  byte unsigned q_tx[$];
  byte unsigned q_rx[$];

  assign u_if.rx     = r_loop ? u_if.tx : r_rx_drv;
  assign u_if.uclktx = dut.utx.uclk;
  assign u_if.uclkrx = dut.rtx.uclk;

  uart_top #(
    .clk_freq (CLK_FREQ),
    .baud_rate(BAUD)
  ) dut (
    .clk   (u_if.clk),
    .rst   (u_if.rst),
    .rx    (u_if.rx),
    .newd  (u_if.newd),
    .dintx (u_if.dintx),
    .tx    (u_if.tx),
    .donetx(u_if.donetx),
    .donerx(u_if.donerx),
    .doutrx(u_if.doutrx)
  );

  initial begin
    u_if.clk = 1'b0;
    forever #10 u_if.clk = ~u_if.clk;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at 5 ms, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_tx_low(input string name);
    int n = 0;
    while (u_if.tx !== 1'b0 && n < int'(3 * DIV)) begin
      @(negedge u_if.clk);
      n++;
    end
    check(name, u_if.tx, 1'b0);
  endtask

  task automatic wait_donetx(input string name);
    int n = 0;
    while (u_if.donetx !== 1'b1 && n < int'(12 * DIV)) begin
      @(negedge u_if.clk);
      n++;
    end
    check(name, u_if.donetx, 1'b1);
  endtask

  task automatic wait_uclk_rise();
    int   n = 0;
    logic p = u_if.uclkrx;
    while (n < int'(2 * DIV)) begin
      @(posedge u_if.clk);
      #1;
      if (!p && u_if.uclkrx) return;
      p = u_if.uclkrx;
      n++;
    end
    n_checks++;
    $display("FAIL uclk_rise_timeout: no rise within %0d clk, expected one", 2 * DIV);
  endtask

  task automatic idle(input int unsigned bits);
    repeat (bits * DIV) @(negedge u_if.clk);
  endtask

  // Line decoder: samples each bit at its centre, frame = {stop, data[7:0], start}.
  initial begin : tx_mon
    logic        prev;
    logic        aborted;
    logic [9:0]  frame;
    logic [9:0]  want;
    int unsigned wait_clk;
    prev = 1'b1;
    forever begin
      @(negedge u_if.clk);
      if (!u_if.rst && prev && !u_if.tx) begin
        aborted = 1'b0;
        frame   = '0;
        for (int i = 0; i < 10 && !aborted; i++) begin
          wait_clk = (i == 0) ? DIV / 2 : DIV;
          for (int c = 0; c < int'(wait_clk) && !aborted; c++) begin
            @(negedge u_if.clk);
            if (u_if.rst) aborted = 1'b1;
          end
          frame[i] = u_if.tx;
        end
        if (!aborted) begin
          if (q_tx.size() == 0) begin
            n_checks++;
            $display("FAIL tx_unexpected_frame: got frame 0x%0h, expected no frame", frame);
          end else begin
            want = {1'b1, q_tx.pop_front(), 1'b0};
            check("tx_frame", frame, want);
          end
        end
      end
      prev = u_if.tx;
    end
  end

  initial begin : donetx_mon
    int w;
    forever begin
      @(negedge u_if.clk);
      if (u_if.donetx === 1'b1) begin
        got_donetx++;
        w = 0;
        while (u_if.donetx === 1'b1 && w < int'(4 * DIV)) begin
          @(negedge u_if.clk);
          w++;
        end
        check("donetx_width", w, DIV);
      end
    end
  end

  initial begin : rx_mon
    int           w;
    byte unsigned want;
    forever begin
      @(negedge u_if.clk);
      if (u_if.donerx === 1'b1) begin
        got_donerx++;
        if (q_rx.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected_byte: got 0x%02h, expected no byte", u_if.doutrx);
        end else begin
          want = q_rx.pop_front();
          check("rx_byte", u_if.doutrx, want);
        end
        w = 0;
        while (u_if.donerx === 1'b1 && w < int'(4 * DIV)) begin
          @(negedge u_if.clk);
          w++;
        end
        check("donerx_width", w, DIV);
      end
    end
  end

  initial begin : stim
    byte unsigned lb[5];
    byte unsigned v;
    byte unsigned abort_bytes[2];

    u_if.rst   = 1'b1;
    u_if.newd  = 1'b0;
    u_if.dintx = '0;
    repeat (5) @(negedge u_if.clk);
    check("rst_tx", u_if.tx, 1'b1);
    check("rst_donetx", u_if.donetx, 1'b0);
    check("rst_donerx", u_if.donerx, 1'b0);
    check("rst_doutrx", u_if.doutrx, 8'h00);
    check("rst_uclktx", u_if.uclktx, 1'b0);
    check("rst_uclkrx", u_if.uclkrx, 1'b0);
    u_if.rst = 1'b0;
    idle(3);

    // Single frame; dintx is scrambled after latching.
    q_tx.push_back(8'hA5);
    exp_donetx++;
    u_if.dintx = 8'hA5;
    u_if.newd  = 1'b1;
    wait_tx_low("a5_start");
    u_if.newd  = 1'b0;
    u_if.dintx = 8'h5A;
    wait_donetx("a5_done");
    idle(2);
    check("uclk_aligned_a", u_if.uclktx, u_if.uclkrx);

    // Receive 8'h3C driven at bit-clock edges.
    v = 8'h3C;
    q_rx.push_back(v);
    exp_donerx++;
    wait_uclk_rise();
    r_rx_drv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_uclk_rise();
      r_rx_drv = v[i];
    end
    wait_uclk_rise();
    r_rx_drv = 1'b1;
    idle(3);
    check("rx_hold_3c", u_if.doutrx, 8'h3C);

    // Loopback, back-to-back with newd held high across frames.
    r_loop = 1'b1;
    foreach (lb[k]) lb[k] = 8'($urandom);
    u_if.dintx = lb[0];
    u_if.newd  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      q_tx.push_back(lb[k]);
      q_rx.push_back(lb[k]);
      exp_donetx++;
      exp_donerx++;
      wait_tx_low("lb_start");
      if (k < 4) u_if.dintx = lb[k + 1];
      else u_if.newd = 1'b0;
      wait_donetx("lb_done");
    end
    idle(3);
    r_loop = 1'b0;
    check("uclk_aligned_b", u_if.uclktx, u_if.uclkrx);

    // newd pulsed while a frame is in flight must not start another one.
    q_tx.push_back(8'h11);
    exp_donetx++;
    u_if.dintx = 8'h11;
    u_if.newd  = 1'b1;
    wait_tx_low("nd_start");
    u_if.newd = 1'b0;
    idle(3);
    u_if.dintx = 8'h22;
    u_if.newd  = 1'b1;
    idle(2);
    u_if.newd = 1'b0;
    wait_donetx("nd_done");
    idle(4);
    check("nd_tx_idle", u_if.tx, 1'b1);

    // Reset in the middle of data bit 4 aborts the frame.
    abort_bytes[0] = 8'hFF;
    abort_bytes[1] = 8'h00;
    for (int a = 0; a < 2; a++) begin
      u_if.dintx = abort_bytes[a];
      u_if.newd  = 1'b1;
      wait_tx_low("abort_start");
      u_if.newd = 1'b0;
      repeat (5 * DIV + DIV / 2) @(negedge u_if.clk);
      u_if.rst = 1'b1;
      #1;
      check("abort_tx_high", u_if.tx, 1'b1);
      check("abort_donetx", u_if.donetx, 1'b0);
      repeat (5) @(negedge u_if.clk);
      check("abort_doutrx", u_if.doutrx, 8'h00);
      u_if.rst = 1'b0;
      idle(3);
    end

    q_tx.push_back(8'h5A);
    exp_donetx++;
    u_if.dintx = 8'h5A;
    u_if.newd  = 1'b1;
    wait_tx_low("post_rst_start");
    u_if.newd = 1'b0;
    wait_donetx("post_rst_done");
    idle(3);

    check("tx_queue_drained", q_tx.size(), 0);
    check("rx_queue_drained", q_rx.size(), 0);
    check("donetx_count", got_donetx, exp_donetx);
    check("donerx_count", got_donerx, exp_donerx);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_top.md
UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 Parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, serial bit rate in bit/s.
REQ-003 Port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port rx  input  1  serial receive line; idles high.
REQ-006 Port newd  input  1  request to transmit dintx.
REQ-007 Port dintx  input  8  byte to transmit.
REQ-008 Port tx  output  1  serial transmit line; idles high.
REQ-009 Port donetx  output  1  transmit-complete flag.
REQ-010 Port donerx  output  1  receive-complete flag.
REQ-011 Port doutrx  output  8  last received byte.
REQ-012 Port order SHALL be clk, rst, rx, newd, dintx, tx, donetx, donerx, doutrx (positional instantiation).

Function
REQ-013 Each sub-module SHALL derive an internal bit clock uclk from clk.
  - DIV = clk_freq/baud_rate (integer truncation); uclk toggles every DIV/2 clk cycles.
  - Default: DIV = 104, so uclk period = 104 clk.
REQ-014 TX and RX uclk SHALL be phase-aligned from reset release; all framing logic advances on uclk rising edges.
REQ-015 Frame format SHALL be: start bit 0, 8 data bits LSB first, stop bit 1, no parity.
REQ-016 TX states SHALL be IDLE, TRANSFER.
REQ-017 In IDLE, tx SHALL be 1 and donetx 0.
REQ-018 At a uclk edge in IDLE with newd=1, TX SHALL latch dintx, drive tx=0 and enter TRANSFER.
REQ-019 In TRANSFER, the next 8 uclk edges SHALL drive data bits 0..7 on tx.
REQ-020 At the 9th uclk edge, TX SHALL drive tx=1 (stop), assert donetx and return to IDLE.
REQ-021 donetx SHALL be cleared at the following uclk edge, so it is high for exactly one uclk period.
REQ-022 newd SHALL be held until sampled at a uclk edge; newd during TRANSFER is ignored; dintx changes after latching do not affect the frame.
REQ-023 RX states SHALL be IDLE, START.
REQ-024 At a uclk edge in IDLE with rx=0, RX SHALL enter START and clear donerx.
REQ-025 In START, RX SHALL sample rx at each of the next 8 uclk edges, LSB first, into an internal shift register.
REQ-026 On the 8th sample, RX SHALL update doutrx with the assembled byte, assert donerx for one uclk period and return to IDLE.
REQ-027 doutrx SHALL hold its value until the next completed frame.
REQ-028 Back-to-back transmission: newd held high SHALL start the next frame at the uclk edge following donetx.
REQ-029 A reset asserted mid-frame SHALL abort the frame immediately: tx=1, and no done flag is raised.

Reset
REQ-030 While rst=1, the block SHALL force tx=1, donetx=0, donerx=0, doutrx=8'h00, uclk=0, divider counters 0, bit counters 0, and both FSMs to IDLE.

Configuration
REQ-031 With macro UART_ASSERT_EN defined, the block SHALL include SVA checks; without it, no assertion code is compiled and functionality is identical. The checks are:
  - tx==1 in TX IDLE.
  - donetx and donerx each high for exactly one uclk period.
  - DIV >= 2 at elaboration.

Structure
REQ-032 Package uart_pkg SHALL hold the state enum types (tx_state_t, rx_state_t) and the constant DATA_BITS=8.
REQ-033 uart_top SHALL instantiate sub-module uart_tx as instance utx and uart_rx as instance rtx; each SHALL contain a signal named uclk, reachable hierarchically (dut.utx.uclk, dut.rtx.uclk).
REQ-034 Interface uart_if SHALL bundle clk, rst, rx, newd, dintx, tx, donetx, donerx, doutrx and monitor-only uclktx and uclkrx.

Verification
REQ-035 Reset: clk period 20 ns, rst=1 for 5 clk -> tx=1, donetx=0, donerx=0, doutrx=8'h00.
REQ-036 TX 8'hA5 with newd=1: tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 104 clk long; donetx high for one uclk period.
REQ-037 RX: drive 0 then 8'h3C LSB first at uclk edges -> doutrx=8'h3C and donerx pulses once.
REQ-038 Loopback (rx tied to tx), 5 random bytes -> each doutrx equals the sent dintx.
REQ-039 rst asserted at bit 4 of an 8'hFF transmission -> tx=1 immediately, no donetx, next frame correct.
REQ-040 newd pulsed during TRANSFER -> ignored; only one frame is sent.
